fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the instruction decoder/control unit.
- Holds the PC and issues word requests to instruction memory over a req/done handshake.
- Buffers up to two fetched instructions and presents the head to decode as opcode/lower_two/full instruction plus PC+2.
- Handles redirect (branch/jump), decode stall, and halt.

Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- ADDR_W, 16: PC and instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- imem_req  out  1  fetch request, level; held until imem_done
- imem_addr  out  ADDR_W  address of the outstanding request; stable while imem_req=1
- imem_rdata  in  ADDR_W  instruction word, valid with imem_done
- imem_done  in  1  one-cycle completion pulse, ≥1 cycle after req rises
- stall  in  1  decode cannot accept head this cycle
- redirect  in  1  load new PC (branch/jump taken)
- redirect_pc  in  ADDR_W  redirect target
- halt  in  1  decoded HALT consumed this cycle
- if_valid  out  1  head entry valid
- if_instr  out  ADDR_W  head instruction
- if_opcode  out  5  if_instr[15:11]
- if_lower_two  out  2  if_instr[1:0]
- if_pc_plus2  out  ADDR_W  address of head + 2
- halted  out  1  fetch stopped

Behaviour:
- Reset (rst=0 at edge): pc=RESET_PC, buffer empty, discard=0, state=FETCH, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc_plus2=0, halted=0. A done arriving in the reset cycle, or with no request outstanding, is ignored.
- Consume: head leaves when if_valid=1 and stall=0. Outputs are held unchanged while stalled.
- States:
  - FETCH: imem_req=1 while buffer occupancy plus outstanding requests <2. Request is issued at the current pc; imem_addr latches pc. On done: entry {rdata, addr+2} is pushed and pc<=pc+2. A new request may rise the cycle after done, giving peak throughput of 1 instruction per 2 cycles with a 1-cycle memory.
  - HALTED: imem_req=0 after any outstanding request completes; that completion is discarded. halted=1 and if_valid=0. Only reset exits.
- Buffer: 2-entry FIFO. Push and pop in the same cycle is legal, including when full. Order is preserved. Overflow cannot occur because req is gated by occupancy.
- Redirect: next cycle the buffer is flushed (if_valid=0) and pc<=redirect_pc. If a request is outstanding, discard<=1: its done is dropped, discard clears, and the next request uses redirect_pc. imem_addr does not change until the outstanding done arrives.
- Halt: state<=HALTED and the buffer is flushed next cycle.
- Priority per cycle: reset > redirect > halt > stall/consume. Redirect and halt together means redirect wins and halt is ignored.
- Redirect in the same cycle as done, with no discard pending: the returned data is dropped and pc<=redirect_pc.
- Arithmetic: PC+2 is modulo 2^16, so 16'hFFFE + 2 = 16'h0000. Bit 0 of redirect_pc is forced to 0.

Decomposition:
- Shared package: RESET_PC default, opcode field bounds [15:11], lower_two bounds [1:0], HALT opcode 5'b00000, NOP opcode 5'b00001, state encoding {FETCH, HALTED}.
- Sub-module: fetch_buf, a 2-entry FIFO of {instr, pc_plus2} with push/pop/flush, count, full, and empty.

Test Plan:
- Reset then memory done 1 cycle after req, stall=0, words 16'hC005,16'h4001,16'h0000 → imem_addr 0x0000,0x0002,0x0004; if_opcode 5'b11000,5'b01000,5'b00000; if_pc_plus2 0x0002,0x0004,0x0006; after halt pulse → halted=1, imem_req stays 0.
- stall=1 for 6 cycles from first valid → buffer fills with 2 entries; imem_req=0 while full; if_instr held; stall release → entries emerge in order, fetch resumes at 0x0004.
- redirect to 0x0040 while request to 0x0002 is outstanding (done after 3 cycles) → that data is never valid; next imem_addr=0x0040; first if_pc_plus2=0x0042.
- redirect=1 and halt=1 in the same cycle → halted stays 0; fetch continues from redirect_pc. Redirect to 0x0013 → imem_addr=0x0012.
- RESET_PC=16'hFFFE → first if_pc_plus2=0x0000; second imem_addr=0x0000.
- rst=0 while a request is outstanding, with done in the reset cycle → all outputs at reset values, if_valid=0; the first post-reset request is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int          ADDR_W_DEF   = 16;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 11;
    localparam int LT_HI  = 1;
    localparam int LT_LO  = 0;

    localparam logic [4:0] OPC_HALT = 5'b00000;
    localparam logic [4:0] OPC_NOP  = 5'b00001;

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {instr, pc_plus2} pairs feeding decode.
module fetch_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wr_instr,
    input  logic [W-1:0] wr_pc_plus2,
    output logic [W-1:0] head_instr,
    output logic [W-1:0] head_pc_plus2,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] instr_r [2];
    logic [W-1:0] pcp2_r  [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign empty         = (count_r == 2'd0);
    assign full          = (count_r == 2'd2);
    assign count         = count_r;
    assign head_instr    = instr_r[rd_ptr_r];
    assign head_pc_plus2 = pcp2_r[rd_ptr_r];
    assign pop_ok_s      = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok_s     = push && (!full || pop_ok_s);

    // Storage, pointers and occupancy; flush empties the FIFO but leaves data in place.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                instr_r[i] <= {W{1'b0}};
                pcp2_r[i]  <= {W{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                instr_r[wr_ptr_r] <= wr_instr;
                pcp2_r[wr_ptr_r]  <= wr_pc_plus2;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one outstanding imem request and a 2-deep buffer
// presenting the head instruction to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [ADDR_W-1:0] imem_rdata,
    input  logic              imem_done,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_instr,
    output logic [4:0]        if_opcode,
    output logic [1:0]        if_lower_two,
    output logic [ADDR_W-1:0] if_pc_plus2,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

    fetch_state_t      state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              req_r, req_s;
    logic              discard_r, discard_s;
    logic              done_s, pending_s;
    logic              push_s, pop_s, flush_s;
    logic [1:0]        occ_next_s;
    logic [1:0]        buf_count_s;
    logic              buf_full_s, buf_empty_s;
    logic [ADDR_W-1:0] head_instr_s, head_pcp2_s;
    logic              head_valid_s;

    assign done_s       = req_r && imem_done;
    assign pending_s    = req_r && !imem_done;
    assign head_valid_s = !buf_empty_s && (state_r == ST_FETCH);

    fetch_buf #(.W(ADDR_W)) u_buf (
        .clk           (clk),
        .rst           (rst),
        .push          (push_s),
        .pop           (pop_s),
        .flush         (flush_s),
        .wr_instr      (imem_rdata),
        .wr_pc_plus2   (addr_r + PC_STEP),
        .head_instr    (head_instr_s),
        .head_pc_plus2 (head_pcp2_s),
        .count         (buf_count_s),
        .full          (buf_full_s),
        .empty         (buf_empty_s)
    );

    // Per-cycle sequencing: completion, redirect > halt > consume, then next request.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        addr_s    = addr_r;
        req_s     = req_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        flush_s   = 1'b0;
        occ_next_s = buf_count_s;
        if (done_s) begin
            discard_s = 1'b0;
        end else begin
            discard_s = discard_r;
        end

        case (state_r)
            ST_FETCH: begin
                if (redirect) begin
                    flush_s = 1'b1;
                    pc_s    = redirect_pc & ALIGN_MASK;
                    // Data still in flight belongs to the old path.
                    if (pending_s) begin
                        discard_s = 1'b1;
                    end else begin
                        discard_s = 1'b0;
                    end
                end else if (halt) begin
                    flush_s = 1'b1;
                    state_s = ST_HALTED;
                end else begin
                    pop_s = head_valid_s && !stall;
                    if (done_s && !discard_r && (!buf_full_s || pop_s)) begin
                        push_s = 1'b1;
                        pc_s   = pc_r + PC_STEP;
                    end else begin
                        push_s = 1'b0;
                    end
                end
            end
            ST_HALTED: begin
                state_s = ST_HALTED;
            end
            default: begin
                state_s = ST_HALTED;
            end
        endcase

        if (flush_s) begin
            occ_next_s = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   occ_next_s = buf_count_s + 2'd1;
                2'b01:   occ_next_s = buf_count_s - 2'd1;
                default: occ_next_s = buf_count_s;
            endcase
        end

        // The address is held while a request is outstanding; a new one starts at pc.
        if (pending_s) begin
            req_s  = 1'b1;
            addr_s = addr_r;
        end else if ((state_s == ST_FETCH) && (occ_next_s < 2'd2)) begin
            req_s  = 1'b1;
            addr_s = pc_s;
        end else begin
            req_s  = 1'b0;
            addr_s = addr_r;
        end
    end

    // Control registers: state, PC, request address/level and discard flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_FETCH;
            pc_r      <= RESET_PC;
            addr_r    <= RESET_PC;
            req_r     <= 1'b0;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            addr_r    <= addr_s;
            req_r     <= req_s;
            discard_r <= discard_s;
        end
    end

    assign imem_req     = req_r;
    assign imem_addr    = addr_r;
    assign if_valid     = head_valid_s;
    assign if_instr     = head_instr_s;
    assign if_opcode    = head_instr_s[OPC_HI:OPC_LO];
    assign if_lower_two = head_instr_s[LT_HI:LT_LO];
    assign if_pc_plus2  = head_pcp2_s;
    assign halted       = (state_r == ST_HALTED);

endmodule
